// File: rtl/dsp_freeze_harness_if.sv
// dsp_freeze_harness_if
//   Bundles every non-clock, non-reset signal of the DSP characterisation harness.
//   master: the fabric/test side (drives stimulus, freeze, config requests and the raw DUT outputs)
//   slave : the harness itself
// Signals
//   freeze     1 = hold all harness stages and the valid tracker
//   in_valid   qualifies in_data
//   in_data    packed stimulus for the DUT (IN_W)
//   dut_in     last input stage, drives the DUT inputs (IN_W)
//   dut_out    raw DUT outputs (OUT_W)
//   out_data   last output stage (OUT_W)
//   out_valid  in_valid delayed by the full round-trip latency
//   cfg_start  request to serialise cfg_word
//   cfg_word   configuration word (CFG_W)
//   cfg_busy   high while the word is being shifted out
//   cfg_done   one-cycle pulse after the last bit
//   cfg_sdo    serial configuration data, MSB first
//   cfg_sen    serial shift enable
interface dsp_freeze_harness_if #(
    parameter int IN_W  = 242,
    parameter int OUT_W = 162,
    parameter int CFG_W = 64
);
    logic             freeze;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             cfg_start;
    logic [CFG_W-1:0] cfg_word;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_sdo;
    logic             cfg_sen;

    modport master (
        output freeze, in_valid, in_data, dut_out, cfg_start, cfg_word,
        input  dut_in, out_data, out_valid, cfg_busy, cfg_done, cfg_sdo, cfg_sen
    );

    modport slave (
        input  freeze, in_valid, in_data, dut_out, cfg_start, cfg_word,
        output dut_in, out_data, out_valid, cfg_busy, cfg_done, cfg_sdo, cfg_sen
    );
endinterface

// File: rtl/dsp_freeze_harness.sv
// dsp_freeze_harness
//   Timing/characterisation harness placed around one DSP instance. Every DUT input passes
//   through IN_STAGES flops and every DUT output through OUT_STAGES flops so the DSP paths are
//   measured flop-to-flop. A freeze input stalls all harness stages and the valid tracker, and
//   an independent FSM serialises a configuration word into the DSP configuration port.
// Ports
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    dsp_freeze_harness_if.slave carrying data path, valid and config signals
module dsp_freeze_harness #(
    parameter int IN_W       = 242,
    parameter int OUT_W      = 162,
    parameter int IN_STAGES  = 1,
    parameter int OUT_STAGES = 1,
    parameter int DUT_LAT    = 3,
    parameter int CFG_W      = 64
) (
    input  logic               clk,
    input  logic               reset,
    dsp_freeze_harness_if.slave bus
);

    // Round-trip latency seen by the valid tracker; always >= 2 since both stage depths are >= 1.
    localparam int VLEN  = IN_STAGES + DUT_LAT + OUT_STAGES;
    localparam int CNT_W = $clog2(CFG_W + 1);

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_SHIFT = 2'd1,
        CFG_DONE  = 2'd2
    } cfg_state_t;

    logic [IN_W-1:0]  in_stage  [IN_STAGES];
    logic [OUT_W-1:0] out_stage [OUT_STAGES];
    logic [VLEN-1:0]  valid_pipe;

    cfg_state_t       state, next_state;
    logic [CFG_W-1:0] shreg, next_shreg;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             busy, done, sdo, sen;

    // Input stages: data is captured regardless of in_valid; freeze holds every stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IN_STAGES; i++) in_stage[i] <= '0;
        end else if (!bus.freeze) begin
            in_stage[0] <= bus.in_data;
            for (int i = 1; i < IN_STAGES; i++) in_stage[i] <= in_stage[i-1];
        end
    end

    // Output stages: same structure on the DUT return path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_STAGES; i++) out_stage[i] <= '0;
        end else if (!bus.freeze) begin
            out_stage[0] <= bus.dut_out;
            for (int i = 1; i < OUT_STAGES; i++) out_stage[i] <= out_stage[i-1];
        end
    end

    // Valid tracker: in_valid presented during a frozen cycle is dropped, not deferred,
    // because the shift only happens on unfrozen cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
        end else if (!bus.freeze) begin
            valid_pipe <= {valid_pipe[VLEN-2:0], bus.in_valid};
        end
    end

    assign bus.dut_in    = in_stage[IN_STAGES-1];
    assign bus.out_data  = out_stage[OUT_STAGES-1];
    assign bus.out_valid = valid_pipe[VLEN-1];

    // Config FSM state and datapath registers; deliberately independent of freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CFG_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            shreg <= next_shreg;
            cnt   <= next_cnt;
        end
    end

    // Config FSM next-state and outputs. Outputs decode purely from the registered state,
    // so an asynchronous reset forces them low immediately.
    always_comb begin
        next_state = state;
        next_shreg = shreg;
        next_cnt   = cnt;
        busy       = 1'b0;
        done       = 1'b0;
        sdo        = 1'b0;
        sen        = 1'b0;
        case (state)
            CFG_IDLE: begin
                if (bus.cfg_start) begin
                    next_shreg = bus.cfg_word;
                    next_cnt   = CNT_W'(CFG_W);
                    next_state = CFG_SHIFT;
                end
            end
            CFG_SHIFT: begin
                busy       = 1'b1;
                sen        = 1'b1;
                sdo        = shreg[CFG_W-1];
                next_shreg = {shreg[CFG_W-2:0], 1'b0};
                next_cnt   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = CFG_DONE;
                end
            end
            CFG_DONE: begin
                done       = 1'b1;
                next_state = CFG_IDLE;
            end
            default: begin
                next_state = CFG_IDLE;
            end
        endcase
    end

    assign bus.cfg_busy = busy;
    assign bus.cfg_done = done;
    assign bus.cfg_sdo  = sdo;
    assign bus.cfg_sen  = sen;

endmodule

// File: tb/tb_dsp_freeze_harness.sv
// tb_dsp_freeze_harness
//   Self-checking bench for dsp_freeze_harness. The DUT return path is emulated by tying
//   dut_out to the low OUT_W bits of dut_in. A queue-based model tracks what every output
//   must be; a compare process checks it each cycle, and directed sequences pin the model
//   with hand-computed values (latency, freeze, serial config, reset mid-stream).
module tb_dsp_freeze_harness;

    localparam int IN_W       = 242;
    localparam int OUT_W      = 162;
    localparam int IN_STAGES  = 2;
    localparam int OUT_STAGES = 1;
    localparam int DUT_LAT    = 3;
    localparam int CFG_W      = 8;
    localparam int LAT        = IN_STAGES + DUT_LAT + OUT_STAGES;

    typedef struct packed {
        logic sen;
        logic sdo;
        logic busy;
        logic done;
    } cfg_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    dsp_freeze_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CFG_W(CFG_W)) hif ();

    dsp_freeze_harness #(
        .IN_W(IN_W), .OUT_W(OUT_W), .IN_STAGES(IN_STAGES),
        .OUT_STAGES(OUT_STAGES), .DUT_LAT(DUT_LAT), .CFG_W(CFG_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(hif)
    );

    // Emulated DUT: zero-latency pass-through of the low bits.
    assign hif.dut_out = hif.dut_in[OUT_W-1:0];

    always #5 clk = ~clk;

    // Reference model state: histories of unfrozen cycles plus a list of pending serial outputs.
    logic [IN_W-1:0]  in_hist [$];
    logic             vhist   [$];
    logic [OUT_W-1:0] dhist   [$];
    cfg_exp_t         cfg_q   [$];
    cfg_exp_t         cfg_cur       = '0;
    logic [IN_W-1:0]  exp_dut_in    = '0;
    logic [OUT_W-1:0] exp_out_data  = '0;
    logic             exp_out_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each unfrozen cycle appends to the histories; outputs are the entries that
    // sit exactly the stage depth (or round-trip latency) back in that history.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_hist.delete();
            vhist.delete();
            dhist.delete();
            cfg_q.delete();
            cfg_cur       = '0;
            exp_dut_in    = '0;
            exp_out_data  = '0;
            exp_out_valid = 1'b0;
        end else begin
            if (!hif.freeze) begin
                dhist.push_front(exp_dut_in[OUT_W-1:0]);
                in_hist.push_front(hif.in_data);
                vhist.push_front(hif.in_valid);
                while (in_hist.size() > 8) void'(in_hist.pop_back());
                while (vhist.size() > 8) void'(vhist.pop_back());
                while (dhist.size() > 8) void'(dhist.pop_back());
                exp_dut_in    = (in_hist.size() >= IN_STAGES) ? in_hist[IN_STAGES-1] : '0;
                exp_out_data  = (dhist.size() >= OUT_STAGES) ? dhist[OUT_STAGES-1] : '0;
                exp_out_valid = (vhist.size() >= LAT) ? vhist[LAT-1] : 1'b0;
            end
            if (cfg_q.size() > 0) begin
                cfg_cur = cfg_q.pop_front();
            end else if (!(cfg_cur.busy || cfg_cur.done) && hif.cfg_start) begin
                for (int b = CFG_W - 1; b >= 0; b--)
                    cfg_q.push_back(cfg_exp_t'{1'b1, hif.cfg_word[b], 1'b1, 1'b0});
                cfg_q.push_back(cfg_exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
                cfg_cur = cfg_q.pop_front();
            end else begin
                cfg_cur = '0;
            end
        end
    end

    // Compare every output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("dut_in",    256'(hif.dut_in),    256'(exp_dut_in));
        checkOutput("out_data",  256'(hif.out_data),  256'(exp_out_data));
        checkOutput("out_valid", 256'(hif.out_valid), 256'(exp_out_valid));
        checkOutput("cfg_sen",   256'(hif.cfg_sen),   256'(cfg_cur.sen));
        checkOutput("cfg_sdo",   256'(hif.cfg_sdo),   256'(cfg_cur.sdo));
        checkOutput("cfg_busy",  256'(hif.cfg_busy),  256'(cfg_cur.busy));
        checkOutput("cfg_done",  256'(hif.cfg_done),  256'(cfg_cur.done));
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        hif.freeze    = 1'b0;
        hif.in_valid  = 1'b0;
        hif.in_data   = '0;
        hif.cfg_start = 1'b0;
        hif.cfg_word  = '0;
    endtask

    task automatic applyStimulus();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        hif.in_data   = r[IN_W-1:0];
        hif.in_valid  = ($urandom_range(0, 1) == 1);
        hif.freeze    = ($urandom_range(0, 3) == 0);
        hif.cfg_start = ($urandom_range(0, 9) == 0);
        hif.cfg_word  = CFG_W'($urandom);
    endtask

    initial begin
        logic [IN_W-1:0] pat;
        logic [7:0]      w1;
        logic [7:0]      w2;
        w1 = 8'hB4;
        w2 = 8'h5A;
        pat = '0;
        pat[7:0]   = 8'hA5;
        pat[200]   = 1'b1;
        clearInputs();
        reset = 1'b1;
        repeat (3) nextCycle();
        reset = 1'b0;
        repeat (8) nextCycle();

        // Reset-state pins
        checkOutput("reset dut_in",    256'(hif.dut_in),    256'(0));
        checkOutput("reset out_valid", 256'(hif.out_valid), 256'(0));
        checkOutput("reset cfg_busy",  256'(hif.cfg_busy),  256'(0));

        // Latency: A5 pulse at cycle 0 reaches dut_in at 2, out_data at 3, out_valid at 6.
        hif.in_data  = pat;
        hif.in_valid = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("lat dut_in c1", 256'(hif.dut_in[7:0]), 256'(8'h00));
            if (c == 2) checkOutput("lat dut_in c2", 256'(hif.dut_in[7:0]), 256'(8'hA5));
            if (c == 3) checkOutput("lat out_data c3", 256'(hif.out_data[7:0]), 256'(8'hA5));
            if (c == 5) checkOutput("lat out_valid c5", 256'(hif.out_valid), 256'(0));
            if (c == 6) checkOutput("lat out_valid c6", 256'(hif.out_valid), 256'(1));
            if (c == 7) checkOutput("lat out_valid c7", 256'(hif.out_valid), 256'(0));
            nextCycle();
            hif.in_valid = 1'b0;
            hif.in_data  = '0;
        end
        repeat (4) nextCycle();

        // Freeze cycles 1..4: out_valid slips to 10, in_valid pulse during freeze is dropped.
        hif.in_data  = pat;
        hif.in_valid = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 5) checkOutput("frz dut_in hold", 256'(hif.dut_in[7:0]), 256'(8'h00));
            if (c == 6)  checkOutput("frz dut_in c6", 256'(hif.dut_in[7:0]), 256'(8'hA5));
            if (c == 7)  checkOutput("frz out_data c7", 256'(hif.out_data[7:0]), 256'(8'hA5));
            if (c == 9)  checkOutput("frz out_valid c9", 256'(hif.out_valid), 256'(0));
            if (c == 10) checkOutput("frz out_valid c10", 256'(hif.out_valid), 256'(1));
            if (c >= 11) checkOutput("frz dropped valid", 256'(hif.out_valid), 256'(0));
            nextCycle();
            hif.freeze   = (c + 1 >= 1 && c + 1 <= 4);
            hif.in_data  = hif.freeze ? IN_W'(8'h3C) : '0;
            hif.in_valid = (c + 1 == 2);
        end
        clearInputs();
        repeat (4) nextCycle();

        // Serial config: B4 at cycle 0, ignored starts at 3 and 9, accepted start at 10 with 5A.
        hif.cfg_start = 1'b1;
        hif.cfg_word  = w1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("cfg sen c0", 256'(hif.cfg_sen), 256'(0));
            if (c >= 1 && c <= 8) begin
                checkOutput("cfg sen", 256'(hif.cfg_sen), 256'(1));
                checkOutput("cfg busy", 256'(hif.cfg_busy), 256'(1));
                checkOutput("cfg sdo1", 256'(hif.cfg_sdo), 256'(w1[8-c]));
                checkOutput("cfg done low", 256'(hif.cfg_done), 256'(0));
            end
            if (c == 9) begin
                checkOutput("cfg done c9", 256'(hif.cfg_done), 256'(1));
                checkOutput("cfg busy c9", 256'(hif.cfg_busy), 256'(0));
                checkOutput("cfg sen c9", 256'(hif.cfg_sen), 256'(0));
            end
            if (c == 10) checkOutput("cfg idle c10", 256'(hif.cfg_busy), 256'(0));
            if (c >= 11 && c <= 18) checkOutput("cfg sdo2", 256'(hif.cfg_sdo), 256'(w2[18-c]));
            if (c == 19) checkOutput("cfg done c19", 256'(hif.cfg_done), 256'(1));
            nextCycle();
            hif.cfg_start = (c + 1 == 3) || (c + 1 == 9) || (c + 1 == 10);
            hif.cfg_word  = (c + 1 == 10) ? w2 : 8'hFF;
        end
        clearInputs();
        repeat (3) nextCycle();

        // Randomised traffic checked by the model.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            nextCycle();
        end
        clearInputs();
        repeat (10) nextCycle();

        // Reset mid-stream with data, valid and a shift in flight.
        hif.in_valid  = 1'b1;
        hif.in_data   = pat;
        hif.cfg_start = 1'b1;
        hif.cfg_word  = 8'hFF;
        nextCycle();
        hif.cfg_start = 1'b0;
        repeat (3) nextCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async dut_in",    256'(hif.dut_in),    256'(0));
        checkOutput("async out_data",  256'(hif.out_data),  256'(0));
        checkOutput("async out_valid", 256'(hif.out_valid), 256'(0));
        checkOutput("async cfg_busy",  256'(hif.cfg_busy),  256'(0));
        checkOutput("async cfg_done",  256'(hif.cfg_done),  256'(0));
        checkOutput("async cfg_sdo",   256'(hif.cfg_sdo),   256'(0));
        checkOutput("async cfg_sen",   256'(hif.cfg_sen),   256'(0));
        nextCycle();
        nextCycle();
        reset = 1'b0;
        clearInputs();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("post-reset out_valid", 256'(hif.out_valid), 256'(0));
            checkOutput("post-reset cfg_done",  256'(hif.cfg_done),  256'(0));
            nextCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
